// File: rtl/smm_pkg.sv
// -----------------------------------------------------------------------------
// smm_pkg
// Shared definitions for the SMM core stream sequencer.
//   state_t        : sequencer FSM states
//   MODE_*         : block mode encodings (full product / off-diagonal only)
//   IDX_*          : 2x2 element indices (row-major: 11, 12, 21, 22)
//   op_lsb()       : bit offset of an element inside a packed operand bus
//   res_lsb()      : bit offset of an element inside the core result bus
// -----------------------------------------------------------------------------
package smm_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam logic MODE_FULL    = 1'b0;
   localparam logic MODE_OFFDIAG = 1'b1;

   localparam logic [1:0] IDX_11 = 2'd0;
   localparam logic [1:0] IDX_12 = 2'd1;
   localparam logic [1:0] IDX_21 = 2'd2;
   localparam logic [1:0] IDX_22 = 2'd3;

   // Operands: element k sits at [k*w +: w] (A11 in the low word).
   function automatic int op_lsb(input logic [1:0] idx, input int w);
      return int'(idx) * w;
   endfunction

   // Results come back in the opposite order: C11 occupies the top word.
   function automatic int res_lsb(input logic [1:0] idx, input int w);
      return (3 - int'(idx)) * w;
   endfunction

endpackage

// File: rtl/smm_seq.sv
// -----------------------------------------------------------------------------
// smm_seq
// Streaming front/back end for one 2x2 Strassen multiplier core.
// Collects eight serial elements (A11..A22, B11..B22), packs them onto the
// core operand buses, strobes the core's load, captures the registered
// product RESULT_LAT cycles later and streams the result back out.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input element handshake
//   in_data                element (A11,A12,A21,A22,B11,B12,B21,B22 order)
//   in_mode                block mode, sampled on the first beat only
//   out_valid/out_ready    result element handshake
//   out_data, out_last     result element, final-word marker
//   busy                   block in progress (anything but idle COLLECT)
//   smm_a, smm_b           packed operands to the core
//   smm_load, smm_sel      one-cycle load strobe and mode select to the core
//   smm_c                  registered core result
// -----------------------------------------------------------------------------
module smm_seq
   import smm_pkg::*;
#(
   parameter int DATAWIDTH  = 32,
   parameter int BUSWIDTH   = 4*DATAWIDTH,
   parameter int RESULT_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic [BUSWIDTH-1:0]  smm_a,
   output logic [BUSWIDTH-1:0]  smm_b,
   output logic                 smm_load,
   output logic                 smm_sel,
   input  logic [BUSWIDTH-1:0]  smm_c
);

   localparam int LAT_W = $clog2(RESULT_LAT + 1);

   state_t               r_state;
   logic [2:0]           r_beat;
   logic [LAT_W-1:0]     r_lat;
   logic                 r_mode;
   logic [1:0]           r_widx;
   logic [BUSWIDTH-1:0]  r_res;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic [DATAWIDTH-1:0] r_out_data;
   logic [BUSWIDTH-1:0]  r_smm_a;
   logic [BUSWIDTH-1:0]  r_smm_b;
   logic                 r_smm_load;
   logic                 r_smm_sel;

   logic                 w_in_fire;
   logic                 w_out_fire;
   logic [1:0]           w_first_idx;
   logic [1:0]           w_next_pos;
   logic [1:0]           w_next_idx;
   logic                 w_next_last;

   function automatic logic [DATAWIDTH-1:0] res_elem(input logic [BUSWIDTH-1:0] bus,
                                                     input logic [1:0]          idx);
      return bus[res_lsb(idx, DATAWIDTH) +: DATAWIDTH];
   endfunction

   assign w_in_fire  = (r_state == COLLECT) && in_valid && r_in_ready;
   assign w_out_fire = (r_state == DRAIN) && r_out_valid && out_ready;

   // Off-diagonal mode walks C12, C21; full mode walks C11..C22. Both are
   // the same index sequence, shifted by one for off-diagonal.
   assign w_first_idx = (r_mode == MODE_OFFDIAG) ? IDX_12 : IDX_11;
   assign w_next_pos  = r_widx + 2'd1;
   assign w_next_idx  = (r_mode == MODE_OFFDIAG) ? (w_next_pos + 2'd1) : w_next_pos;
   assign w_next_last = (w_next_idx == ((r_mode == MODE_OFFDIAG) ? IDX_21 : IDX_22));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= COLLECT;
         r_beat      <= '0;
         r_lat       <= '0;
         r_mode      <= MODE_FULL;
         r_widx      <= '0;
         r_res       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_smm_a     <= '0;
         r_smm_b     <= '0;
         r_smm_load  <= 1'b0;
         r_smm_sel   <= 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (w_in_fire) begin
                  if (!r_beat[2]) begin
                     r_smm_a[op_lsb(r_beat[1:0], DATAWIDTH) +: DATAWIDTH] <= in_data;
                  end else begin
                     r_smm_b[op_lsb(r_beat[1:0], DATAWIDTH) +: DATAWIDTH] <= in_data;
                  end
                  if (r_beat == 3'd0) begin
                     r_mode    <= in_mode;
                     r_smm_sel <= in_mode;
                  end
                  // 3-bit counter wraps back to 0 after beat 7, leaving it
                  // ready for the next block once DRAIN finishes.
                  r_beat <= r_beat + 3'd1;
                  if (r_beat == 3'd7) begin
                     r_state    <= ISSUE;
                     r_in_ready <= 1'b0;
                     r_smm_load <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               r_smm_load <= 1'b0;
               r_lat      <= LAT_W'(RESULT_LAT - 1);
               r_state    <= WAIT;
            end

            WAIT: begin
               if (r_lat == '0) begin
                  r_res       <= smm_c;
                  r_out_data  <= res_elem(smm_c, w_first_idx);
                  r_out_last  <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_widx      <= '0;
                  r_state     <= DRAIN;
               end else begin
                  r_lat <= r_lat - 1'b1;
               end
            end

            DRAIN: begin
               if (w_out_fire) begin
                  if (r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_widx      <= '0;
                     r_beat      <= '0;
                     r_in_ready  <= 1'b1;
                     r_state     <= COLLECT;
                  end else begin
                     r_widx     <= w_next_pos;
                     r_out_data <= res_elem(r_res, w_next_idx);
                     r_out_last <= w_next_last;
                  end
               end
            end

            default: begin
               r_state <= COLLECT;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign smm_a     = r_smm_a;
   assign smm_b     = r_smm_b;
   assign smm_load  = r_smm_load;
   assign smm_sel   = r_smm_sel;
   assign busy      = (r_state != COLLECT) || (r_beat != 3'd0);

endmodule

// File: tb/tb_smm_seq.sv
// -----------------------------------------------------------------------------
// tb_smm_seq
// Bench for smm_seq paired with a behavioural stand-in for the SMM core.
// The core stand-in computes the product with Strassen's seven products and
// presents it on smm_c only in the cycle RESULT_LAT after the load cycle
// (a marker pattern otherwise). The expected stream comes from the plain
// row-by-column definition of the matrix product.
// -----------------------------------------------------------------------------
module tb_smm_seq;
   import smm_pkg::*;

   localparam int W  = 32;
   localparam int BW = 4*W;
   localparam int RL = 2;

   typedef logic [W-1:0] mat_t [4];

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic          busy;
   logic [BW-1:0] smm_a;
   logic [BW-1:0] smm_b;
   logic          smm_load;
   logic          smm_sel;
   logic [BW-1:0] smm_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   smm_seq #(.DATAWIDTH(W), .BUSWIDTH(BW), .RESULT_LAT(RL)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .smm_a(smm_a), .smm_b(smm_b), .smm_load(smm_load), .smm_sel(smm_sel),
      .smm_c(smm_c)
   );

   // ---------------- core stand-in ----------------
   logic [RL-1:0] core_tok;
   always @(posedge clk) begin
      if (rst) core_tok <= '0;
      else     core_tok <= {core_tok[RL-2:0], smm_load};
   end

   function automatic logic [BW-1:0] strassen(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                              input logic sel);
      logic [W-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
      logic [W-1:0] m1, m2, m3, m4, m5, m6, m7, c11, c12, c21, c22;
      a11 = a[0+:W];   a12 = a[W+:W];   a21 = a[2*W+:W]; a22 = a[3*W+:W];
      b11 = b[0+:W];   b12 = b[W+:W];   b21 = b[2*W+:W]; b22 = b[3*W+:W];
      m1 = (a11 + a22) * (b11 + b22);
      m2 = (a21 + a22) * b11;
      m3 = a11 * (b12 - b22);
      m4 = a22 * (b21 - b11);
      m5 = (a11 + a12) * b22;
      m6 = (a21 - a11) * (b11 + b12);
      m7 = (a12 - a22) * (b21 + b22);
      c11 = m1 + m4 - m5 + m7;
      c12 = m3 + m5;
      c21 = m2 + m4;
      c22 = m1 - m2 + m3 + m6;
      if (sel) begin
         c11 = '0;
         c22 = '0;
      end
      return {c11, c12, c21, c22};
   endfunction

   assign smm_c = core_tok[RL-1] ? strassen(smm_a, smm_b, smm_sel) : {4{32'hBAD0_C0DE}};

   // ---------------- monitors ----------------
   int cyc = 0;
   int load_cnt = 0;
   int load_cyc = -1;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (smm_load) begin
         load_cnt <= load_cnt + 1;
         load_cyc <= cyc;
      end
   end

   logic sel_watch = 1'b0;
   logic sel_exp   = 1'b0;
   int   sel_err_cnt = 0;
   always @(negedge clk) begin
      if (sel_watch && (smm_sel !== sel_exp)) sel_err_cnt <= sel_err_cnt + 1;
   end

   // ---------------- reference model ----------------
   logic [W-1:0] exp_q [$];

   function automatic void ref_model(input mat_t a, input mat_t b, input logic mode);
      logic [W-1:0] c [2][2];
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            c[i][j] = '0;
            for (int k = 0; k < 2; k++) c[i][j] += a[2*i+k] * b[2*k+j];
         end
      end
      if (mode == MODE_FULL) begin
         exp_q.push_back(c[0][0]); exp_q.push_back(c[0][1]);
         exp_q.push_back(c[1][0]); exp_q.push_back(c[1][1]);
      end else begin
         exp_q.push_back(c[0][1]); exp_q.push_back(c[1][0]);
      end
   endfunction

   // ---------------- stimulus / capture helpers (no checking) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_block(input mat_t a, input mat_t b, input logic mode, input int nbeats,
                              input int max_gap, output int beat7_cyc, output logic rejected);
      int gap;
      rejected  = 1'b0;
      beat7_cyc = -1;
      for (int k = 0; k < nbeats; k++) begin
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            tick();
         end
         in_valid = 1'b1;
         in_data  = (k < 4) ? a[k] : b[k-4];
         in_mode  = (k == 0) ? mode : 1'($urandom);
         if (!in_ready) rejected = 1'b1;
         if (k == 7) beat7_cyc = cyc;
         tick();
         if (k == 0) begin
            sel_exp   = mode;
            sel_watch = 1'b1;
         end
      end
      in_valid = 1'b0;
      in_data  = $urandom;
   endtask

   logic [W-1:0] got_data [$];
   logic         got_last [$];
   logic         col_timeout;
   logic         stall_changed;
   logic         ready_in_drain;
   int           first_valid_cyc;

   // stall < 0 picks a random 0..3 cycle stall for every word.
   task automatic collect_out(input int stall);
      int           waited;
      int           hold_left;
      logic [W-1:0] held;
      logic         have_held;
      logic         done;
      got_data.delete();
      got_last.delete();
      col_timeout = 1'b0; stall_changed = 1'b0; ready_in_drain = 1'b0;
      first_valid_cyc = -1;
      waited = 0; have_held = 1'b0; done = 1'b0; held = '0;
      hold_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      while (!done) begin
         if (out_valid) begin
            if (first_valid_cyc < 0) begin
               first_valid_cyc = cyc;
               sel_watch = 1'b0;
            end
            if (in_ready) ready_in_drain = 1'b1;
            if (have_held && (out_data !== held)) stall_changed = 1'b1;
            held = out_data;
            have_held = 1'b1;
            if (hold_left > 0) begin
               out_ready = 1'b0;
               hold_left--;
            end else begin
               out_ready = 1'b1;
               got_data.push_back(out_data);
               got_last.push_back(out_last);
               have_held = 1'b0;
               hold_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
               if (out_last || got_data.size() >= 8) done = 1'b1;
            end
         end else begin
            out_ready = (stall == 0);
         end
         tick();
         waited++;
         if (!done && waited > 300) begin
            col_timeout = 1'b1;
            done = 1'b1;
         end
      end
      out_ready = 1'b0;
      sel_watch = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({in_ready, out_valid, out_last, smm_load, smm_sel, busy} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl: {in_ready,out_valid,out_last,smm_load,smm_sel,busy} got %b expected 100000",
                  {in_ready, out_valid, out_last, smm_load, smm_sel, busy});
      end
      checks++;
      if (out_data !== '0) begin
         errors++; $display("FAIL reset_out_data: got %h expected 0", out_data);
      end
      checks++;
      if ({smm_a, smm_b} !== '0) begin
         errors++; $display("FAIL reset_operands: got a=%h b=%h expected 0", smm_a, smm_b);
      end
      rst = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_directed();
      mat_t  da [4];
      mat_t  db [4];
      logic  dm [4];
      string nm [4];
      int    b7, l0, s0;
      logic  rej;
      da[0] = '{32'd1, 32'd2, 32'd3, 32'd4};  db[0] = '{32'd5, 32'd6, 32'd7, 32'd8};  dm[0] = 1'b0; nm[0] = "full";
      da[1] = '{32'd1, 32'd2, 32'd3, 32'd4};  db[1] = '{32'd5, 32'd6, 32'd7, 32'd8};  dm[1] = 1'b1; nm[1] = "offdiag";
      da[2] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
      db[2] = '{32'd2, 32'd3, 32'd4, 32'd5};  dm[2] = 1'b0; nm[2] = "negatives";
      da[3] = '{32'h7FFF_FFFF, 32'd0, 32'd0, 32'd1};
      db[3] = '{32'd2, 32'd0, 32'd0, 32'd1};  dm[3] = 1'b0; nm[3] = "wrap";
      for (int t = 0; t < 4; t++) begin
         ref_model(da[t], db[t], dm[t]);
         l0 = load_cnt;
         s0 = sel_err_cnt;
         drive_block(da[t], db[t], dm[t], 8, 0, b7, rej);
         checks++;
         if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_beat7: got %b expected 1", nm[t], busy);
         end
         collect_out(0);
         checks++;
         if (rej !== 1'b0) begin
            errors++; $display("FAIL %s in_ready_collect: beat refused, expected all accepted", nm[t]);
         end
         checks++;
         if (col_timeout !== 1'b0) begin
            errors++; $display("FAIL %s timeout: no out_last within budget", nm[t]);
         end
         checks++;
         if (load_cnt - l0 !== 1) begin
            errors++; $display("FAIL %s load_pulses: got %0d expected 1", nm[t], load_cnt - l0);
         end
         checks++;
         if (load_cyc !== b7 + 1) begin
            errors++; $display("FAIL %s load_timing: load at cycle %0d expected %0d", nm[t], load_cyc, b7 + 1);
         end
         checks++;
         if (first_valid_cyc - load_cyc !== RL + 1) begin
            errors++; $display("FAIL %s out_latency: got %0d expected %0d", nm[t], first_valid_cyc - load_cyc, RL + 1);
         end
         checks++;
         if (sel_err_cnt !== s0) begin
            errors++; $display("FAIL %s smm_sel_hold: %0d bad cycles expected 0", nm[t], sel_err_cnt - s0);
         end
         checks++;
         if (got_data.size() !== exp_q.size()) begin
            errors++; $display("FAIL %s word_count: got %0d expected %0d", nm[t], got_data.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i]) begin
               errors++; $display("FAIL %s data[%0d]: got %h expected %h", nm[t], i, got_data[i], exp_q[i]);
            end
            checks++;
            if (got_last[i] !== (i == exp_q.size() - 1)) begin
               errors++; $display("FAIL %s last[%0d]: got %b expected %b", nm[t], i, got_last[i], (i == exp_q.size() - 1));
            end
         end
         checks++;
         if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++; $display("FAIL %s post_drain {out_valid,in_ready,busy}: got %b expected 010", nm[t], {out_valid, in_ready, busy});
         end
         $display("test_directed %s: %0d words", nm[t], got_data.size());
      end
   endtask

   task automatic test_backpressure();
      mat_t a, b;
      int   b7;
      logic rej;
      for (int blk = 0; blk < 2; blk++) begin
         for (int k = 0; k < 4; k++) begin a[k] = $urandom; b[k] = $urandom; end
         ref_model(a, b, 1'(blk));
         drive_block(a, b, 1'(blk), 8, 1, b7, rej);
         collect_out(blk == 0 ? 3 : -1);
         checks++;
         if (col_timeout !== 1'b0 || rej !== 1'b0) begin
            errors++; $display("FAIL bp%0d handshake: timeout=%b rejected=%b expected 0 0", blk, col_timeout, rej);
         end
         checks++;
         if (stall_changed !== 1'b0) begin
            errors++; $display("FAIL bp%0d out_data_stable: changed while stalled, expected held", blk);
         end
         checks++;
         if (ready_in_drain !== 1'b0) begin
            errors++; $display("FAIL bp%0d in_ready_drain: got 1 during drain expected 0", blk);
         end
         checks++;
         if (got_data.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp%0d word_count: got %0d expected %0d", blk, got_data.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
               errors++; $display("FAIL bp%0d word[%0d]: got %h/%b expected %h/%b", blk, i, got_data[i], got_last[i],
                                  exp_q[i], (i == exp_q.size() - 1));
            end
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp%0d in_ready_after: got %b expected 1", blk, in_ready);
         end
         $display("test_backpressure block %0d: %0d words", blk, got_data.size());
      end
   endtask

   task automatic test_reset_mid();
      mat_t a, b;
      int   b7, l0, seen;
      logic rej;
      for (int k = 0; k < 4; k++) begin a[k] = $urandom | 32'h1; b[k] = $urandom | 32'h1; end
      l0 = load_cnt;
      drive_block(a, b, 1'b1, 6, 0, b7, rej);
      sel_watch = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, out_last, smm_load, smm_sel, busy} !== 6'b100000) begin
         errors++;
         $display("FAIL midreset_ctrl: {in_ready,out_valid,out_last,smm_load,smm_sel,busy} got %b expected 100000",
                  {in_ready, out_valid, out_last, smm_load, smm_sel, busy});
      end
      checks++;
      if ({smm_a, smm_b} !== '0) begin
         errors++; $display("FAIL midreset_operands: got a=%h b=%h expected 0", smm_a, smm_b);
      end
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) seen++;
         tick();
      end
      checks++;
      if (seen !== 0 || load_cnt !== l0) begin
         errors++; $display("FAIL midreset_quiet: valid cycles %0d loads %0d expected 0 0", seen, load_cnt - l0);
      end
      a = '{32'd2, 32'd0, 32'd0, 32'd2};
      b = '{32'd1, 32'd2, 32'd3, 32'd4};
      ref_model(a, b, 1'b0);
      drive_block(a, b, 1'b0, 8, 0, b7, rej);
      collect_out(0);
      checks++;
      if (got_data.size() !== 4) begin
         errors++; $display("FAIL midreset_fresh_count: got %0d expected 4", got_data.size());
      end
      for (int i = 0; i < 4 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 3)) begin
            errors++; $display("FAIL midreset_fresh[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_q[i], (i == 3));
         end
      end
      $display("test_reset_mid: fresh block %0d words", got_data.size());
   endtask

   task automatic test_random();
      mat_t a, b;
      logic m, rej;
      int   b7, s0, bad;
      for (int n = 0; n < 25; n++) begin
         for (int k = 0; k < 4; k++) begin a[k] = $urandom; b[k] = $urandom; end
         m = 1'($urandom);
         ref_model(a, b, m);
         s0 = sel_err_cnt;
         drive_block(a, b, m, 8, 2, b7, rej);
         collect_out(-1);
         bad = 0;
         for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) bad++;
         end
         checks++;
         if (bad != 0 || got_data.size() !== exp_q.size() || col_timeout || rej || stall_changed
             || sel_err_cnt != s0 || first_valid_cyc - load_cyc != RL + 1) begin
            errors++;
            $display("FAIL random%0d mode=%0d: bad_words=%0d count=%0d/%0d timeout=%b rej=%b stall_chg=%b sel_err=%0d lat=%0d expected all clean lat=%0d",
                     n, m, bad, got_data.size(), exp_q.size(), col_timeout, rej, stall_changed,
                     sel_err_cnt - s0, first_valid_cyc - load_cyc, RL + 1);
         end
         $display("test_random %0d mode=%0d words=%0d", n, m, got_data.size());
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
